// File: rtl/n_bit_sipo_deser.sv
// Serial-in/parallel-out deserializer: rebuilds WIDTH-bit words from a framed,
// strobed serial stream and presents each word with a one-cycle valid pulse.
// Optional even-parity trailer bit enabled by defining SIPO_PARITY_EN.
module n_bit_sipo_deser #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_serial,
    input  logic             i_bit_en,
    input  logic             i_sync,
    output logic [WIDTH-1:0] o_parallel,
    output logic             o_valid,
    output logic             o_busy,
    output logic             o_err_sync,
    output logic             o_parity_err
);

`ifdef SIPO_PARITY_EN
    localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
    localparam int unsigned FRAME_LEN = WIDTH;
`endif
    localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   par_d;
    logic               valid_d;
    logic               err_d;
    logic [WIDTH-1:0]   sr_shift;
    logic [WIDTH-1:0]   sr_first;
`ifdef SIPO_PARITY_EN
    logic               perr_q, perr_d;
`endif

    // Shift register advanced by one bit, and a fresh register holding only bit 0
    always_comb begin
        if (MSB_FIRST != 0) begin
            sr_shift = {sr_q[WIDTH-2:0], i_serial};
            sr_first = {{(WIDTH-1){1'b0}}, i_serial};
        end else begin
            sr_shift = {i_serial, sr_q[WIDTH-1:1]};
            sr_first = {i_serial, {(WIDTH-1){1'b0}}};
        end
    end

    // Next-state, datapath and output decode
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        par_d   = o_parallel;
        valid_d = 1'b0;
        err_d   = 1'b0;
`ifdef SIPO_PARITY_EN
        perr_d  = perr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (i_bit_en && i_sync) begin
                    state_d = SHIFT;
                    sr_d    = sr_first;
                    cnt_d   = CNT_W'(1);
                end
            end
            SHIFT: begin
                if (i_bit_en) begin
                    if (i_sync) begin
                        // New frame marker mid-frame: drop partial word, restart at bit 0
                        err_d = 1'b1;
                        sr_d  = sr_first;
                        cnt_d = CNT_W'(1);
                    end else if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        valid_d = 1'b1;
`ifdef SIPO_PARITY_EN
                        // Last bit is the parity trailer; data already sits in sr_q
                        par_d  = sr_q;
                        perr_d = (^sr_q) ^ i_serial;
`else
                        par_d  = sr_shift;
                        sr_d   = sr_shift;
`endif
                    end else begin
                        sr_d  = sr_shift;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            cnt_q      <= '0;
            o_parallel <= '0;
            o_valid    <= 1'b0;
            o_busy     <= 1'b0;
            o_err_sync <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            o_parallel <= par_d;
            o_valid    <= valid_d;
            o_busy     <= (state_d == SHIFT);
            o_err_sync <= err_d;
        end
    end

`ifdef SIPO_PARITY_EN
    // Parity result, held between completions
    always_ff @(posedge clk) begin
        if (rst) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign o_parity_err = perr_q;
`else
    assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_n_bit_sipo_deser.sv
// Bench for n_bit_sipo_deser: LSB-first and MSB-first instances share one
// stimulus stream; a frame-level model derives every expected output.
module tb_n_bit_sipo_deser;

    localparam int W = 8;
`ifdef SIPO_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk = 1'b0;
    logic         rst, i_serial, i_bit_en, i_sync;
    logic [W-1:0] par_a, par_b;
    logic         val_a, val_b, busy_a, busy_b, es_a, es_b, pe_a, pe_b;

    int n_cmp = 0;
    int n_bad = 0;

    // model state
    logic         mbits[$];
    logic         m_in_frame = 1'b0;
    logic [W-1:0] e_par_a = '0, e_par_b = '0;
    logic         e_val = 1'b0, e_err = 1'b0, e_pe = 1'b0;

    n_bit_sipo_deser #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .i_serial(i_serial), .i_bit_en(i_bit_en), .i_sync(i_sync),
        .o_parallel(par_a), .o_valid(val_a), .o_busy(busy_a), .o_err_sync(es_a),
        .o_parity_err(pe_a)
    );

    n_bit_sipo_deser #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .i_serial(i_serial), .i_bit_en(i_bit_en), .i_sync(i_sync),
        .o_parallel(par_b), .o_valid(val_b), .o_busy(busy_b), .o_err_sync(es_b),
        .o_parity_err(pe_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame-level reference: collect bits of the current frame, emit a word when full
    task automatic model_edge(input logic r, input logic s, input logic en, input logic sy);
        logic [W-1:0] wa, wb;
        logic         px;
        e_val = 1'b0;
        e_err = 1'b0;
        if (r) begin
            mbits.delete();
            m_in_frame = 1'b0;
            e_par_a = '0;
            e_par_b = '0;
            e_pe = 1'b0;
        end else if (en) begin
            if (sy) begin
                e_err = m_in_frame;
                mbits.delete();
                mbits.push_back(s);
                m_in_frame = 1'b1;
            end else if (m_in_frame) begin
                mbits.push_back(s);
            end
            if (m_in_frame && mbits.size() == FL) begin
                wa = '0;
                wb = '0;
                px = 1'b0;
                for (int i = 0; i < FL; i++) begin
                    px = px ^ mbits[i];
                    if (i < W) begin
                        wa[i]       = mbits[i];
                        wb[W-1-i]   = mbits[i];
                    end
                end
                e_par_a = wa;
                e_par_b = wb;
`ifdef SIPO_PARITY_EN
                e_pe = px;
`endif
                e_val = 1'b1;
                m_in_frame = 1'b0;
                mbits.delete();
            end
        end
    endtask

    // One clock: drive inputs, clock, then compare both instances against the model
    task automatic step(input logic r, input logic s, input logic en, input logic sy);
        rst = r; i_serial = s; i_bit_en = en; i_sync = sy;
        @(posedge clk);
        #1;
        model_edge(r, s, en, sy);
        chk("lsb_parallel", 64'(par_a), 64'(e_par_a));
        chk("msb_parallel", 64'(par_b), 64'(e_par_b));
        chk("lsb_valid", 64'(val_a), 64'(e_val));
        chk("msb_valid", 64'(val_b), 64'(e_val));
        chk("lsb_busy", 64'(busy_a), 64'(m_in_frame));
        chk("msb_busy", 64'(busy_b), 64'(m_in_frame));
        chk("lsb_err_sync", 64'(es_a), 64'(e_err));
        chk("msb_err_sync", 64'(es_b), 64'(e_err));
        chk("lsb_parity_err", 64'(pe_a), 64'(e_pe));
        chk("msb_parity_err", 64'(pe_b), 64'(e_pe));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'($urandom), 1'b0, 1'($urandom));
    endtask

    // Send n bits of v (index 0 first) with gap idle cycles between bits
    task automatic send_bits(input logic [63:0] v, input int n, input int gap, input logic first_sync);
        for (int i = 0; i < n; i++) begin
            step(1'b0, v[i], 1'b1, (i == 0) ? first_sync : 1'b0);
            if (gap > 0 && i != n - 1) idle(gap);
        end
    endtask

    // Whole frame: data LSB-first in v, plus parity trailer when enabled
    task automatic send_frame(input logic [W-1:0] v, input int gap, input logic flip_par);
        logic [63:0] fv;
        fv = 64'(v);
`ifdef SIPO_PARITY_EN
        fv[W] = (^v) ^ flip_par;
`else
        fv[W] = flip_par & 1'b0;
`endif
        send_bits(fv, FL, gap, 1'b1);
    endtask

    initial begin
        logic [W-1:0] rev;
        // reset held with random inputs
        for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
        chk("reset_parallel", 64'(par_a), 64'd0);

        // 0xA5 contiguous
        send_frame(8'hA5, 0, 1'b0);
        chk("a5_word", 64'(par_a), 64'hA5);
        chk("a5_valid", 64'(val_a), 64'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("a5_valid_drop", 64'(val_a), 64'd0);

        // 0x3C MSB-first with strobe every 3rd cycle
        rev = '0;
        for (int i = 0; i < W; i++) rev[i] = 8'h3C >> (W - 1 - i);
        send_frame(rev, 2, 1'b0);
        chk("3c_msb_word", 64'(par_b), 64'h3C);
        idle(3);

        // sync restart after 4 bits, then 0x81
        send_bits(64'hF, 4, 0, 1'b1);
        send_frame(8'h81, 0, 1'b0);
        chk("81_word", 64'(par_a), 64'h81);

        // back-to-back frames
        send_frame(8'h5A, 0, 1'b0);
        send_frame(8'hC3, 1, 1'b0);
        chk("c3_word", 64'(par_a), 64'hC3);

        // reset mid-frame, then 0xFF
        send_bits(64'h55, 5, 0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("mid_reset_parallel", 64'(par_a), 64'd0);
        send_frame(8'hFF, 0, 1'b0);
        chk("ff_word", 64'(par_a), 64'hFF);

`ifdef SIPO_PARITY_EN
        send_frame(8'hA5, 0, 1'b0);
        chk("par_ok", 64'(pe_a), 64'd0);
        send_frame(8'hA5, 0, 1'b1);
        chk("par_bad", 64'(pe_a), 64'd1);
        chk("par_bad_valid", 64'(val_a), 64'd1);
`endif

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 149) == 0), 1'($urandom),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 13) == 0));
        end
        for (int i = 0; i < 20; i++) send_frame(W'($urandom), $urandom_range(0, 2), 1'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
